frac_clk_div: RTL
=================

Name: frac_clk_div

Overview:
Runtime-programmable fractional clock divider. It produces clk_out with an average period of DIV_INT + FRAC_NUM/FRAC_DEN input clocks. Each output period is either DIV_INT or DIV_INT+1 cycles, and an accumulator spreads the long periods evenly across each FRAC_DEN-period frame instead of grouping them. It sits in the clock-logic area as the configurable successor to the fixed M/N dividers and is driven from a register block through a valid/ready config port.

Parameters:
CNT_W, 8, width of div_int and of the in-period cycle counter
FRAC_W, 8, width of frac_num and frac_den; the accumulator is FRAC_W+1 bits
RST_DIV, 8, div_int value active out of reset
RST_NUM, 7, frac_num value active out of reset
RST_DEN, 10, frac_den value active out of reset

Ports:
clk_in  input  1  divider source clock
rst  input  1  asynchronous, active-high reset
en  input  1  run request, level-sensitive
cfg_valid  input  1  new configuration offered
cfg_ready  output  1  config port can accept a new configuration (no shadow pending)
cfg_div  input  CNT_W  integer divisor N
cfg_num  input  FRAC_W  fractional numerator
cfg_den  input  FRAC_W  fractional denominator
cfg_err  output  1  one-cycle pulse: offered configuration rejected
clk_out  output  1  divided clock, registered
period_start  output  1  one-cycle pulse on the first high cycle of each output period
long_period  output  1  held for the whole period: 1 if the current period is DIV_INT+1
busy  output  1  state is RUN

Behaviour:
- Clock and reset: one clock, clk_in. rst is asynchronous and active-high.
- Reset values: clk_out=0, period_start=0, long_period=0, busy=0, cfg_err=0, cfg_ready=1. Internal: state=IDLE, pc=0, acc=0, shadow empty. Active config = RST_DIV/RST_NUM/RST_DEN.
- Config transfer: a transfer happens when cfg_valid && cfg_ready.
  - Validity check: cfg_div>=2, cfg_den>=1, cfg_num<cfg_den.
  - Invalid: cfg_err pulses on the next cycle; no state changes.
  - Valid: the config goes to the shadow and cfg_ready drops on the next cycle.
- Shadow apply:
  - In IDLE: the shadow is applied on the following cycle.
  - In RUN: the shadow is applied at the next period boundary (the cycle where pc==P-1 ends the period).
  - On apply: the active config is copied, acc is cleared to 0 and cfg_ready returns to 1.
- State machine: two states, IDLE and RUN.
  - IDLE -> RUN: en is sampled high. pc is set to 0.
  - RUN -> IDLE: en is sampled low at a period boundary. A period in progress always completes; it is never truncated.
- Period decision (at pc==0 in RUN):
  - s = acc + num, computed at FRAC_W+1 bits.
  - If s >= den: long period, P = div+1, acc <= s - den.
  - Otherwise: short period, P = div, acc <= s.
  - long_period is updated on the same cycle as the decision.
- Counter: pc runs 0..P-1 and wraps to 0. P is computed at CNT_W+1 bits, so div = 2^CNT_W-1 with a long period is legal.
- Output timing:
  - clk_out(t+1) = RUN(t) && pc(t) < (P>>1). The output is high for floor(P/2) cycles and low for the rest.
  - period_start(t+1) = RUN(t) && pc(t)==0.
  - Latency: 1 clk_in cycle from sampling en to the first clk_out high.
- Edge cases:
  - num=0: every period is short, giving an exact integer divide.
  - div=2: the output is 1 high, 1 low, or 1 high, 2 low when the period is long.
- Reset mid-period: all outputs drop immediately to their reset values, asynchronously.
- Simultaneous events:
  - en falls and a shadow applies on the same boundary: the config applies first, then the block goes to IDLE.
  - cfg_valid is offered during an apply cycle: not accepted, because cfg_ready is still 0.

Optional Feature:
FRAC_DIV_BLOCK_MODE_EN
- Defined: adds input block_mode, sampled only at the shadow apply.
- With block_mode=1, the accumulator is bypassed. The first (den-num) periods of each den-period frame are short and the remaining num periods are long, counted by a frame counter that is cleared on apply.
- Not defined: the port and frame counter are absent, and distribution is always accumulator-based.

Test Plan:
- Reset defaults (div=8, num=7, den=10), en=1 -> 10-period frame pattern S L L S L L S L L L, exactly 87 clk_in per frame, 3 short and 7 long, repeating.
- cfg (div=5, num=0, den=1) offered mid-period -> accepted and cfg_ready=0 until the boundary; from the next period on, every period is 5 cycles (2 high, 3 low), long_period=0, acc=0.
- Invalid cfg (num=4, den=4), then (div=1) -> cfg_err pulses once for each; output pattern unchanged; cfg_ready stays 1.
- en drops at pc=3 of a 9-cycle period -> period completes, busy falls after pc=8, clk_out stays 0; en rises again -> first clk_out high 1 cycle later, with period_start on the same cycle.
- rst asserted mid-high-phase -> clk_out=0 and busy=0 with no clock edge; after release with en=1, the frame restarts with a short first period (acc=0).
- Max div (div=255, num=1, den=2) -> periods alternate 255/256, P computed without overflow, 127 and 128 high cycles respectively.

Source files
------------

// File: rtl/frac_clk_div.sv
// -----------------------------------------------------------------------------
// frac_clk_div
//
// Runtime-programmable fractional clock divider. clk_out has an average period
// of div + num/den input clocks. Every output period is either div or div+1
// cycles long. An accumulator spreads the long periods evenly over each
// den-period frame. The duty cycle is floor(P/2) high, and the remainder low.
//
// A new configuration arrives through a valid/ready port. It is range checked
// and parked in a shadow register. The shadow becomes active at the next
// period boundary (or on the next cycle when idle). The accumulator restarts
// from zero whenever a configuration is applied.
//
// Optional build macro: FRAC_DIV_BLOCK_MODE_EN
//    When this macro is defined, the block_mode input is added. It is sampled
//    when the shadow is applied. With block_mode=1, each den-period frame has
//    (den-num) short periods followed by num long periods, and a frame counter
//    is used instead of the accumulator.
//
// Ports:
//    clk_in        divider source clock
//    rst           asynchronous active-high reset
//    en            run request (level); a started period always completes
//    block_mode    (FRAC_DIV_BLOCK_MODE_EN only) block distribution select
//    cfg_valid     new configuration offered
//    cfg_ready     no shadow configuration pending
//    cfg_div       integer divisor (>= 2)
//    cfg_num       fractional numerator (< cfg_den)
//    cfg_den       fractional denominator (>= 1)
//    cfg_err       one-cycle pulse: offered configuration rejected
//    clk_out       divided clock, registered
//    period_start  one-cycle pulse on the first high cycle of each period
//    long_period   1 for the whole of a div+1 period
//    busy          divider is running
// -----------------------------------------------------------------------------
module frac_clk_div #(
   parameter int CNT_W   = 8,
   parameter int FRAC_W  = 8,
   parameter int RST_DIV = 8,
   parameter int RST_NUM = 7,
   parameter int RST_DEN = 10
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              en,
`ifdef FRAC_DIV_BLOCK_MODE_EN
   input  logic              block_mode,
`endif
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic [FRAC_W-1:0] cfg_num,
   input  logic [FRAC_W-1:0] cfg_den,
   output logic              cfg_err,
   output logic              clk_out,
   output logic              period_start,
   output logic              long_period,
   output logic              busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_reg, state_next;

   // Period counter and length are one bit wider than div. This lets
   // div = 2^CNT_W-1 with a long period be represented.
   logic [CNT_W:0]    pc_reg, pc_next;
   logic [CNT_W:0]    p_reg, p_next;
   logic [FRAC_W:0]   acc_reg, acc_next;

   logic [CNT_W-1:0]  div_reg, div_next;
   logic [FRAC_W-1:0] num_reg, num_next;
   logic [FRAC_W-1:0] den_reg, den_next;

   logic [CNT_W-1:0]  sh_div_reg, sh_div_next;
   logic [FRAC_W-1:0] sh_num_reg, sh_num_next;
   logic [FRAC_W-1:0] sh_den_reg, sh_den_next;
   logic              sh_valid_reg, sh_valid_next;

   logic              cfg_err_reg, cfg_err_next;
   logic              clk_out_reg, clk_out_next;
   logic              ps_reg, ps_next;
   logic              long_reg, long_next;

`ifdef FRAC_DIV_BLOCK_MODE_EN
   logic [FRAC_W-1:0] fc_reg, fc_next;
   logic              blk_reg, blk_next;
`endif

   logic [FRAC_W:0]   s_sum;
   logic              dec_long;
   logic [CNT_W:0]    p_dec;
   logic [CNT_W:0]    p_cur;
   logic              at_boundary;
   logic              cfg_ok;
   logic              xfer;
   logic              apply;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         pc_reg       <= '0;
         p_reg        <= '0;
         acc_reg      <= '0;
         div_reg      <= CNT_W'(RST_DIV);
         num_reg      <= FRAC_W'(RST_NUM);
         den_reg      <= FRAC_W'(RST_DEN);
         sh_div_reg   <= '0;
         sh_num_reg   <= '0;
         sh_den_reg   <= '0;
         sh_valid_reg <= 1'b0;
         cfg_err_reg  <= 1'b0;
         clk_out_reg  <= 1'b0;
         ps_reg       <= 1'b0;
         long_reg     <= 1'b0;
`ifdef FRAC_DIV_BLOCK_MODE_EN
         fc_reg       <= '0;
         blk_reg      <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         p_reg        <= p_next;
         acc_reg      <= acc_next;
         div_reg      <= div_next;
         num_reg      <= num_next;
         den_reg      <= den_next;
         sh_div_reg   <= sh_div_next;
         sh_num_reg   <= sh_num_next;
         sh_den_reg   <= sh_den_next;
         sh_valid_reg <= sh_valid_next;
         cfg_err_reg  <= cfg_err_next;
         clk_out_reg  <= clk_out_next;
         ps_reg       <= ps_next;
         long_reg     <= long_next;
`ifdef FRAC_DIV_BLOCK_MODE_EN
         fc_reg       <= fc_next;
         blk_reg      <= blk_next;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Period decision: evaluated every cycle, but only used at pc==0.
   // acc < den and num < den, so the sum fits in FRAC_W+1 bits.
   // ------------------------------------------------------------------
   always_comb begin
      s_sum    = acc_reg + {1'b0, num_reg};
      dec_long = (s_sum >= {1'b0, den_reg});
`ifdef FRAC_DIV_BLOCK_MODE_EN
      if (blk_reg) begin
         dec_long = (fc_reg >= (den_reg - num_reg));
      end
`endif
      p_dec = {1'b0, div_reg} + {{CNT_W{1'b0}}, dec_long};
      // p_reg is only loaded at pc==0. In that cycle, the freshly decided
      // length is used directly.
      p_cur       = (pc_reg == '0) ? p_dec : p_reg;
      at_boundary = (state_reg == RUN) && (pc_reg == (p_cur - 1'b1));
      cfg_ok      = (cfg_div >= CNT_W'(2)) && (cfg_den != '0) && (cfg_num < cfg_den);
      xfer        = cfg_valid && !sh_valid_reg;
      apply       = sh_valid_reg && ((state_reg == IDLE) || at_boundary);
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      p_next        = p_reg;
      acc_next      = acc_reg;
      div_next      = div_reg;
      num_next      = num_reg;
      den_next      = den_reg;
      sh_div_next   = sh_div_reg;
      sh_num_next   = sh_num_reg;
      sh_den_next   = sh_den_reg;
      sh_valid_next = sh_valid_reg;
      long_next     = long_reg;
`ifdef FRAC_DIV_BLOCK_MODE_EN
      fc_next       = fc_reg;
      blk_next      = blk_reg;
`endif

      clk_out_next  = (state_reg == RUN) && (pc_reg < (p_cur >> 1));
      ps_next       = (state_reg == RUN) && (pc_reg == '0);
      cfg_err_next  = xfer && !cfg_ok;

      if (xfer && cfg_ok) begin
         sh_div_next   = cfg_div;
         sh_num_next   = cfg_num;
         sh_den_next   = cfg_den;
         sh_valid_next = 1'b1;
      end

      case (state_reg)
         IDLE: begin
            if (en) begin
               state_next = RUN;
               pc_next    = '0;
            end
         end
         RUN: begin
            if (pc_reg == '0) begin
               p_next    = p_dec;
               long_next = dec_long;
               acc_next  = dec_long ? (s_sum - {1'b0, den_reg}) : s_sum;
`ifdef FRAC_DIV_BLOCK_MODE_EN
               fc_next   = (fc_reg >= (den_reg - 1'b1)) ? '0 : fc_reg + 1'b1;
`endif
            end
            if (at_boundary) begin
               pc_next = '0;
               if (!en) begin
                  state_next = IDLE;
               end
            end else begin
               pc_next = pc_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // P >= 2 means a boundary never coincides with a pc==0 decision.
      // Therefore the accumulator clear here cannot collide with an update.
      if (apply) begin
         div_next      = sh_div_reg;
         num_next      = sh_num_reg;
         den_next      = sh_den_reg;
         acc_next      = '0;
         sh_valid_next = 1'b0;
`ifdef FRAC_DIV_BLOCK_MODE_EN
         fc_next       = '0;
         blk_next      = block_mode;
`endif
      end
   end

   assign cfg_ready    = !sh_valid_reg;
   assign cfg_err      = cfg_err_reg;
   assign clk_out      = clk_out_reg;
   assign period_start = ps_reg;
   assign long_period  = long_reg;
   assign busy         = (state_reg == RUN);

endmodule
